// File: rtl/multicycle_controller.sv
// Control unit for the multi-cycle ARM-subset datapath.
// Decodes INSTR, sequences a 10-state FSM and gates all architectural writes on CondEx.
//
// Ports:
//   CLK        in   rising-edge clock
//   RESET      in   asynchronous active-low reset
//   INSTR      in   instruction register {Cond, Op, Funct, Rn, Rd, Src2}
//   ALUFlags   in   {N,Z,C,V} produced by the ALU this cycle
//   PCWrite    out  PC register enable
//   IRWrite    out  instruction register enable
//   RegWrite   out  register file write enable
//   MemWrite   out  data memory write enable
//   AdrSrc     out  memory address: 0=PC, 1=ALUOut
//   ALUSrcA    out  ALU A operand: 0=RD1, 1=PC
//   ALUSrcB    out  ALU B operand: 00=shifted RD2, 01=ExtImm, 10=4
//   ResultSrc  out  result bus: 00=ALUOut, 01=ReadData, 10=ALUResult
//   ALUControl out  ARM cmd code for the ALU
//   ImmSrc     out  immediate extender select (equals Op)
//   RegSrc     out  [0]=read R15 as RA1 (branch), [1]=read Rd as RA2 (STR)
//   Flags      out  architectural NZCV register
//   STATE      out  FSM state, debug only
module multicycle_controller (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] INSTR,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [3:0]  ALUControl,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [3:0]  Flags,
    output logic [3:0]  STATE
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_e;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    state_e     state_q;
    state_e     state_d;
    logic [3:0] flags_q;
    logic [3:0] flags_d;

    // Instruction fields
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;

    assign cond  = INSTR[31:28];
    assign op    = INSTR[27:26];
    assign funct = INSTR[25:20];
    assign rd    = INSTR[15:12];

    // Rn and the operand-2 field are consumed by the datapath only.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{INSTR[19:16], INSTR[11:0]};

    logic no_write;
    logic rd_is_pc;
    logic cond_ex;

    // CMP updates flags only; it never targets a register.
    assign no_write = (op == OP_DP) && (funct[4:1] == CMD_CMP);
    assign rd_is_pc = (rd == 4'hF);

    // Condition check reads the stored flags, not the live ALU flags.
    logic flag_n;
    logic flag_z;
    logic flag_c;
    logic flag_v;

    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = flag_z;
            4'b0001: cond_ex = ~flag_z;
            4'b0010: cond_ex = flag_c;
            4'b0011: cond_ex = ~flag_c;
            4'b0100: cond_ex = flag_n;
            4'b0101: cond_ex = ~flag_n;
            4'b0110: cond_ex = flag_v;
            4'b0111: cond_ex = ~flag_v;
            4'b1000: cond_ex = flag_c & ~flag_z;
            4'b1001: cond_ex = ~flag_c | flag_z;
            4'b1010: cond_ex = (flag_n == flag_v);
            4'b1011: cond_ex = (flag_n != flag_v);
            4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_ex = flag_z | (flag_n != flag_v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Instruction-static selects, valid in every state.
    assign ImmSrc = op;
    assign RegSrc = {(op == OP_MEM) && !funct[0], op == OP_BR};

    // State and flag registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_FETCH;
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    // Raw write enables before reset gating.
    logic pc_we;
    logic ir_we;
    logic reg_we;
    logic mem_we;

    always_comb begin
        state_d    = state_q;
        flags_d    = flags_q;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        mem_we     = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = CMD_ADD;

        unique case (state_q)
            S_FETCH: begin
                ir_we     = 1'b1;
                pc_we     = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                unique case (op)
                    OP_DP:   state_d = funct[5] ? S_EXECI : S_EXECR;
                    OP_MEM:  state_d = S_MEMADR;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
                state_d = funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_we    = cond_ex;
                pc_we     = cond_ex & rd_is_pc;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc  = 1'b1;
                mem_we  = cond_ex;
                state_d = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                ALUSrcB    = (state_q == S_EXECI) ? 2'b01 : 2'b00;
                ALUControl = funct[4:1];
                if (funct[0] && cond_ex) begin
                    flags_d = ALUFlags;
                end
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_we  = cond_ex & ~no_write;
                pc_we   = cond_ex & ~no_write & rd_is_pc;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                pc_we     = cond_ex;
                state_d   = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Enables are forced low for as long as reset is held.
    assign PCWrite  = pc_we & RESET;
    assign IRWrite  = ir_we & RESET;
    assign RegWrite = reg_we & RESET;
    assign MemWrite = mem_we & RESET;

    assign Flags = flags_q;
    assign STATE = state_q;

endmodule
